// File: rtl/l2sw_pkg.sv
// Shared definitions for the 4-port L2 switch: widths, FSM states and
// the small MAC/port helpers used by the learning table.
package l2sw_pkg;

   localparam int PHY_NUM    = 4;
   localparam int MAC_W      = 48;
   localparam int PORT_IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      LEARN,
      RESP
   } state_t;

   // Group bit is the LSB of the first octet, i.e. bit 40 of the 48-bit value.
   function automatic logic is_mcast(input logic [MAC_W-1:0] mac);
      return mac[40];
   endfunction

   function automatic logic [PHY_NUM-1:0] flood_mask(input logic [PORT_IDX_W-1:0] src_port);
      logic [PHY_NUM-1:0] m;
      m = '1;
      if (int'(src_port) < PHY_NUM) m[src_port] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/mac_table_entry.sv
// One slot of the MAC learning table: valid/mac/port/age registers with a
// write port, an aging input and combinational DA/SA match outputs.
module mac_table_entry
   import l2sw_pkg::*;
#(
   parameter int AGE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  tick,
   input  logic                  wr_en,
   input  logic [MAC_W-1:0]      wr_mac,
   input  logic [PORT_IDX_W-1:0] wr_port,
   input  logic [MAC_W-1:0]      da_mac,
   input  logic [MAC_W-1:0]      sa_mac,
   output logic                  valid,
   output logic [PORT_IDX_W-1:0] port,
   output logic [AGE_W-1:0]      age,
   output logic                  da_match,
   output logic                  sa_match
);

   // Reaching the all-ones age expires the entry, so the counter never saturates.
   localparam logic [AGE_W-1:0] AGE_LAST = {{(AGE_W-1){1'b1}}, 1'b0};

   logic [MAC_W-1:0] mac;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         mac   <= '0;
         port  <= '0;
         age   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (wr_en) begin
         valid <= 1'b1;
         mac   <= wr_mac;
         port  <= wr_port;
         age   <= '0;
      end else if (tick && valid) begin
         if (age == AGE_LAST) begin
            valid <= 1'b0;
            age   <= '0;
         end else begin
            age <= age + AGE_W'(1);
         end
      end
   end

   assign da_match = valid && (mac == da_mac);
   assign sa_match = valid && (mac == sa_mac);

endmodule

// File: rtl/mac_learn_table.sv
// Source-MAC learning and destination lookup: sequential scan of a small
// fully associative table, then learn, then hold the egress mask.
//
//   state | meaning
//   IDLE  | apply pending flush/tick, else accept a request
//   SCAN  | compare entry scan_idx against DA and SA, track free/victim
//   LEARN | write SA->port, register mask and hit
//   RESP  | hold response until resp_ready
module mac_learn_table
   import l2sw_pkg::*;
#(
   parameter int PORT_NUM = PHY_NUM,
   parameter int ADDR_LEN = 3,
   parameter int AGE_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [MAC_W-1:0]      req_dst_mac,
   input  logic [MAC_W-1:0]      req_src_mac,
   input  logic [PORT_IDX_W-1:0] req_src_port,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [PORT_NUM-1:0]   resp_port_mask,
   output logic                  resp_hit,
   input  logic                  age_tick,
   input  logic                  flush
);

   localparam int ENTRIES = 2**ADDR_LEN;

   state_t                state, state_next;
   logic [ADDR_LEN-1:0]   scan_idx;
   logic [MAC_W-1:0]      da_q, sa_q;
   logic [PORT_IDX_W-1:0] src_q;
   logic                  flush_pend, tick_pend;
   logic                  do_flush, do_tick, accept;

   logic                  da_hit, sa_hit, free_found;
   logic [PORT_IDX_W-1:0] da_port;
   logic [ADDR_LEN-1:0]   sa_idx, free_idx, victim_idx, wr_idx;
   logic [AGE_W-1:0]      victim_age;

   logic [ENTRIES-1:0]    ent_valid, ent_da_match, ent_sa_match, ent_wr;
   logic [PORT_IDX_W-1:0] ent_port [ENTRIES];
   logic [AGE_W-1:0]      ent_age  [ENTRIES];

   logic                  learn_ok, hit_next;
   logic [PORT_NUM-1:0]   mask_next;

   for (genvar k = 0; k < ENTRIES; k++) begin : g_entry
      mac_table_entry #(.AGE_W(AGE_W)) u_entry (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (do_flush),
         .tick     (do_tick),
         .wr_en    (ent_wr[k]),
         .wr_mac   (sa_q),
         .wr_port  (src_q),
         .da_mac   (da_q),
         .sa_mac   (sa_q),
         .valid    (ent_valid[k]),
         .port     (ent_port[k]),
         .age      (ent_age[k]),
         .da_match (ent_da_match[k]),
         .sa_match (ent_sa_match[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Maintenance in IDLE outranks requests: flush, then tick, then accept.
   always_comb begin
      state_next = state;
      do_flush   = 1'b0;
      do_tick    = 1'b0;
      accept     = 1'b0;
      req_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (flush || flush_pend) begin
               do_flush = 1'b1;
            end else if (age_tick || tick_pend) begin
               do_tick = 1'b1;
            end else begin
               req_ready = rst_n;
               if (req_valid && rst_n) begin
                  accept     = 1'b1;
                  state_next = SCAN;
               end
            end
         end
         SCAN:    if (&scan_idx) state_next = LEARN;
         LEARN:   state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      learn_ok  = !is_mcast(sa_q) && (sa_q != '0) && (int'(src_q) < PORT_NUM);
      wr_idx    = sa_hit ? sa_idx : (free_found ? free_idx : victim_idx);
      ent_wr    = '0;
      if (state == LEARN && learn_ok) ent_wr[wr_idx] = 1'b1;
      hit_next  = 1'b0;
      mask_next = flood_mask(src_q);
      if (!is_mcast(da_q) && da_hit) begin
         hit_next  = 1'b1;
         mask_next = (da_port == src_q) ? '0 : (PORT_NUM'(1) << da_port);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_idx       <= '0;
         da_q           <= '0;
         sa_q           <= '0;
         src_q          <= '0;
         flush_pend     <= 1'b0;
         tick_pend      <= 1'b0;
         da_hit         <= 1'b0;
         da_port        <= '0;
         sa_hit         <= 1'b0;
         sa_idx         <= '0;
         free_found     <= 1'b0;
         free_idx       <= '0;
         victim_idx     <= '0;
         victim_age     <= '0;
         resp_port_mask <= '0;
         resp_hit       <= 1'b0;
      end else begin
         flush_pend <= !do_flush && (flush_pend || flush);
         tick_pend  <= !do_tick && (tick_pend || age_tick);
         if (accept) begin
            da_q       <= req_dst_mac;
            sa_q       <= req_src_mac;
            src_q      <= req_src_port;
            scan_idx   <= '0;
            da_hit     <= 1'b0;
            sa_hit     <= 1'b0;
            free_found <= 1'b0;
            victim_idx <= '0;
            victim_age <= '0;
         end
         // Strict compare keeps the lowest index among equally old entries.
         if (state == SCAN) begin
            scan_idx <= scan_idx + ADDR_LEN'(1);
            if (ent_da_match[scan_idx]) begin
               da_hit  <= 1'b1;
               da_port <= ent_port[scan_idx];
            end
            if (ent_sa_match[scan_idx]) begin
               sa_hit <= 1'b1;
               sa_idx <= scan_idx;
            end
            if (!ent_valid[scan_idx] && !free_found) begin
               free_found <= 1'b1;
               free_idx   <= scan_idx;
            end
            if (ent_age[scan_idx] > victim_age) begin
               victim_idx <= scan_idx;
               victim_age <= ent_age[scan_idx];
            end
         end
         if (state == LEARN) begin
            resp_port_mask <= mask_next;
            resp_hit       <= hit_next;
         end
      end
   end

   assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_mac_learn_table.sv
// Bench for mac_learn_table: directed scenarios with literal expectations
// plus randomized traffic, all compared against a behavioural table model.
module tb_mac_learn_table;

   localparam int ENTRIES = 8;
   localparam int AGE_MAX = 15;
   localparam int LAT     = ENTRIES + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [47:0] req_dst_mac = '0;
   logic [47:0] req_src_mac = '0;
   logic [1:0]  req_src_port = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [3:0]  resp_port_mask;
   logic        resp_hit;
   logic        tick_drv = 1'b0, flush_drv = 1'b0;
   logic        rnd_tick = 1'b0, rnd_flush = 1'b0;
   logic        age_tick_in, flush_in;

   assign age_tick_in = tick_drv | rnd_tick;
   assign flush_in    = flush_drv | rnd_flush;

   always #5 clk = ~clk;

   mac_learn_table dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_dst_mac    (req_dst_mac),
      .req_src_mac    (req_src_mac),
      .req_src_port   (req_src_port),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_port_mask (resp_port_mask),
      .resp_hit       (resp_hit),
      .age_tick       (age_tick_in),
      .flush          (flush_in)
   );

   // ---------------- behavioural model ----------------
   bit          m_valid [ENTRIES];
   logic [47:0] m_mac   [ENTRIES];
   logic [1:0]  m_port  [ENTRIES];
   int          m_age   [ENTRIES];
   bit          m_fp, m_tp, m_busy;
   int          m_cnt;
   logic [3:0]  m_mask;
   logic        m_hit;

   function automatic logic [3:0] flood(input logic [1:0] s);
      return 4'hF & ~(4'h1 << s);
   endfunction

   task automatic model_request();
      int w;
      logic dh;
      logic [1:0] dp;
      dh = 1'b0;
      dp = 2'd0;
      for (int i = 0; i < ENTRIES; i++)
         if (m_valid[i] && m_mac[i] == req_dst_mac) begin dh = 1'b1; dp = m_port[i]; end
      if (req_dst_mac[40] || !dh) begin
         m_hit  = 1'b0;
         m_mask = flood(req_src_port);
      end else begin
         m_hit  = 1'b1;
         m_mask = (dp == req_src_port) ? 4'h0 : (4'h1 << dp);
      end
      if (!req_src_mac[40] && req_src_mac != 48'h0) begin
         w = -1;
         for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_mac[i] == req_src_mac) w = i;
         if (w < 0)
            for (int i = 0; i < ENTRIES; i++)
               if (w < 0 && !m_valid[i]) w = i;
         if (w < 0) begin
            w = 0;
            for (int i = 1; i < ENTRIES; i++) if (m_age[i] > m_age[w]) w = i;
         end
         m_valid[w] = 1'b1;
         m_mac[w]   = req_src_mac;
         m_port[w]  = req_src_port;
         m_age[w]   = 0;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 1'b0; m_age[i] = 0; end
         m_fp = 1'b0; m_tp = 1'b0; m_busy = 1'b0; m_cnt = 0;
         m_mask = 4'h0; m_hit = 1'b0;
      end else if (m_busy) begin
         m_fp = m_fp | flush_in;
         m_tp = m_tp | age_tick_in;
         if (m_cnt >= LAT && resp_ready) m_busy = 1'b0;
         else m_cnt++;
      end else if (flush_in || m_fp) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
         m_fp = 1'b0;
         m_tp = m_tp | age_tick_in;
      end else if (age_tick_in || m_tp) begin
         for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i]) begin
               m_age[i]++;
               if (m_age[i] >= AGE_MAX) begin m_valid[i] = 1'b0; m_age[i] = 0; end
            end
         m_tp = 1'b0;
      end else if (req_valid) begin
         model_request();
         m_busy = 1'b1;
         m_cnt  = 1;
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit done = 1'b0;
   bit rnd_en = 1'b0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic do_req(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] src,
                         input int hold, input bit pulse,
                         output logic [3:0] m, output logic h);
      int n, lat;
      req_dst_mac  = da;
      req_src_mac  = sa;
      req_src_port = src;
      req_valid    = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("req_ready_timeout", 48'd0, 48'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 50) begin
         tick_drv  = pulse && (lat == 3);
         flush_drv = pulse && (lat == 3);
         @(posedge clk); #1;
         lat++;
      end
      tick_drv  = 1'b0;
      flush_drv = 1'b0;
      check("latency", 48'(lat), 48'(LAT));
      repeat (hold) begin @(posedge clk); #1; end
      resp_ready = 1'b1;
      m = resp_port_mask;
      h = resp_hit;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic pulse_tick(input int n);
      repeat (n) begin
         tick_drv = 1'b1;
         @(posedge clk); #1;
         tick_drv = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_flush();
      flush_drv = 1'b1;
      @(posedge clk); #1;
      flush_drv = 1'b0;
   endtask

   initial begin
      logic [3:0]  m;
      logic        h;
      logic [47:0] pool [12];
      logic [47:0] mx, my, mz, da, sa;
      bit          seen;
      bit          exp_rr, exp_rv;

      fork
         begin
            while (!done) begin
               @(negedge clk);
               if (chk_en) begin
                  exp_rr = rst_n && !m_busy && !(flush_in || m_fp) && !(age_tick_in || m_tp);
                  exp_rv = m_busy && (m_cnt >= LAT);
                  check("req_ready", 48'(req_ready), 48'(exp_rr));
                  check("resp_valid", 48'(resp_valid), 48'(exp_rv));
                  if (exp_rv) begin
                     check("resp_port_mask", 48'(resp_port_mask), 48'(m_mask));
                     check("resp_hit", 48'(resp_hit), 48'(m_hit));
                  end
               end
            end
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               rnd_tick  = rnd_en && ($urandom_range(5) == 0);
               rnd_flush = rnd_en && ($urandom_range(96) == 0);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 chk_en = 1'b1;
            @(negedge clk);
            check("rst_req_ready", 48'(req_ready), 48'd0);
            check("rst_resp_valid", 48'(resp_valid), 48'd0);
            check("rst_mask", 48'(resp_port_mask), 48'd0);
            check("rst_hit", 48'(resp_hit), 48'd0);
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            check("first_idle_ready", 48'(req_ready), 48'd1);
            @(posedge clk); #1;

            // basic miss, hit, filter, broadcast
            do_req(48'h001122334455, 48'h020000000001, 2'd0, 0, 0, m, h);
            check("t1_mask", 48'(m), 48'hE); check("t1_hit", 48'(h), 48'd0);
            do_req(48'h020000000001, 48'h0, 2'd2, 1, 0, m, h);
            check("t2_mask", 48'(m), 48'h1); check("t2_hit", 48'(h), 48'd1);
            do_req(48'h020000000001, 48'h0, 2'd0, 0, 0, m, h);
            check("t2_filter_mask", 48'(m), 48'h0); check("t2_filter_hit", 48'(h), 48'd1);
            do_req(48'hFFFFFFFFFFFF, 48'h010000000007, 2'd3, 0, 0, m, h);
            check("t3_mask", 48'(m), 48'h7); check("t3_hit", 48'(h), 48'd0);

            // fill, age all, refresh all but slot 5, learn a ninth SA
            pulse_flush();
            do_req(48'hFFFFFFFFFFFF, 48'h010000000009, 2'd1, 0, 0, m, h);
            for (int i = 0; i < 8; i++)
               do_req(48'hFFFFFFFFFFFF, 48'h020000000100 + 48'(i), 2'(i % 4), 0, 0, m, h);
            pulse_tick(3);
            for (int i = 0; i < 8; i++)
               if (i != 5) do_req(48'hFFFFFFFFFFFF, 48'h020000000100 + 48'(i), 2'(i % 4), 0, 0, m, h);
            do_req(48'hFFFFFFFFFFFF, 48'h020000000108, 2'd1, 0, 0, m, h);
            do_req(48'h020000000105, 48'h0, 2'd0, 0, 0, m, h);
            check("t4_evicted_mask", 48'(m), 48'hE); check("t4_evicted_hit", 48'(h), 48'd0);
            do_req(48'h020000000108, 48'h0, 2'd0, 0, 0, m, h);
            check("t4_new_mask", 48'(m), 48'h2); check("t4_new_hit", 48'(h), 48'd1);
            do_req(48'h020000000104, 48'h0, 2'd0, 0, 0, m, h);
            check("t4_kept_mask", 48'(m), 48'h0); check("t4_kept_hit", 48'(h), 48'd1);

            // aging to expiry and refresh at age 14
            mx = 48'h020000000A00;
            my = 48'h020000000B00;
            pulse_flush();
            do_req(48'hFFFFFFFFFFFF, mx, 2'd2, 0, 0, m, h);
            do_req(48'hFFFFFFFFFFFF, my, 2'd3, 0, 0, m, h);
            pulse_tick(14);
            do_req(mx, 48'h0, 2'd0, 0, 0, m, h);
            check("t5_age14_mask", 48'(m), 48'h4); check("t5_age14_hit", 48'(h), 48'd1);
            do_req(48'hFFFFFFFFFFFF, my, 2'd3, 0, 0, m, h);
            pulse_tick(1);
            do_req(mx, 48'h0, 2'd0, 0, 0, m, h);
            check("t5_expired_mask", 48'(m), 48'hE); check("t5_expired_hit", 48'(h), 48'd0);
            do_req(my, 48'h0, 2'd0, 0, 0, m, h);
            check("t5_refreshed_mask", 48'(m), 48'h8); check("t5_refreshed_hit", 48'(h), 48'd1);

            // tick+flush during scan, response stalled 5 cycles
            do_req(my, 48'h0, 2'd0, 5, 1, m, h);
            check("t6_mask", 48'(m), 48'h8); check("t6_hit", 48'(h), 48'd1);
            @(negedge clk); check("t6_flush_cycle_ready", 48'(req_ready), 48'd0);
            @(negedge clk); check("t6_tick_cycle_ready", 48'(req_ready), 48'd0);
            @(negedge clk); check("t6_after_ready", 48'(req_ready), 48'd1);
            @(posedge clk); #1;
            do_req(my, 48'h0, 2'd0, 0, 0, m, h);
            check("t6_flushed_mask", 48'(m), 48'hE); check("t6_flushed_hit", 48'(h), 48'd0);

            // reset in the middle of a request
            mz = 48'h020000000C00;
            do_req(48'hFFFFFFFFFFFF, mz, 2'd1, 0, 0, m, h);
            req_dst_mac = mz; req_src_mac = 48'h0; req_src_port = 2'd0; req_valid = 1'b1;
            @(posedge clk); #1 req_valid = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            rst_n = 1'b1;
            seen = 1'b0;
            repeat (15) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
            check("midrst_no_resp", 48'(seen), 48'd0);
            @(posedge clk); #1;
            do_req(mz, 48'h0, 2'd0, 0, 0, m, h);
            check("midrst_cleared_mask", 48'(m), 48'hE); check("midrst_cleared_hit", 48'(h), 48'd0);

            // randomized traffic against the model
            for (int i = 0; i < 12; i++) pool[i] = 48'h020000001000 + 48'(i);
            rnd_en = 1'b1;
            for (int t = 0; t < 250; t++) begin
               case ($urandom_range(7))
                  0:       da = 48'hFFFFFFFFFFFF;
                  1:       da = {$urandom(), 16'h0} | 48'h010000000000;
                  default: da = pool[$urandom_range(11)];
               endcase
               case ($urandom_range(9))
                  0:       sa = 48'h0;
                  1:       sa = 48'h0100000000AA;
                  default: sa = pool[$urandom_range(11)];
               endcase
               do_req(da, sa, 2'($urandom_range(3)), int'($urandom_range(3)), 0, m, h);
            end
            rnd_en = 1'b0;
            repeat (4) @(posedge clk);
            done = 1'b1;
         end
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
